// File: rtl/router_pkg.sv
// Shared types and defaults for the 1x3 router packet-sequencing controller.
package router_pkg;

  localparam int unsigned NUM_PORTS_DEF = 3;
  localparam int unsigned ADDR_W_DEF    = 2;
  localparam logic [1:0]  ADDR_INVALID  = 2'd3;

  typedef enum logic [2:0] {
    DECODE_ADDRESS     = 3'd0,
    LOAD_FIRST_DATA    = 3'd1,
    LOAD_DATA          = 3'd2,
    LOAD_PARITY        = 3'd3,
    FIFO_FULL_STATE    = 3'd4,
    LOAD_AFTER_FULL    = 3'd5,
    WAIT_TILL_EMPTY    = 3'd6,
    CHECK_PARITY_ERROR = 3'd7
  } state_e;

endpackage

// File: rtl/router_fsm_watchdog.sv
// Cycle counter bounding the time spent in WAIT_TILL_EMPTY; timeout_o flags the
// last allowed cycle.
module router_fsm_watchdog #(
  parameter int unsigned WAIT_TIMEOUT = 30
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic enable_i,
  output logic timeout_o
);

  localparam int unsigned CW = (WAIT_TIMEOUT > 1) ? $clog2(WAIT_TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(WAIT_TIMEOUT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign timeout_o = enable_i && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i && !timeout_o) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/router_fsm.sv
// Packet-sequencing FSM for the 1x3 router. Optional WAIT_TILL_EMPTY timeout
// abort is enabled by defining ROUTER_FSM_TIMEOUT_EN.
module router_fsm
  import router_pkg::*;
#(
  parameter int unsigned NUM_PORTS    = NUM_PORTS_DEF,
  parameter int unsigned ADDR_W       = ADDR_W_DEF,
  parameter int unsigned WAIT_TIMEOUT = 30
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 pkt_valid,
  input  logic [ADDR_W-1:0]    data_in,
  input  logic                 fifo_full,
  input  logic [NUM_PORTS-1:0] fifo_empty,
  input  logic [NUM_PORTS-1:0] soft_reset,
  input  logic                 parity_done,
  input  logic                 low_packet_valid,
  output logic                 detect_add,
  output logic                 lfd_state,
  output logic                 ld_state,
  output logic                 laf_state,
  output logic                 full_state,
  output logic                 rst_int_reg,
  output logic                 write_enb_reg,
  output logic                 busy,
  output logic [ADDR_W-1:0]    dest_addr,
  output logic                 drop_pkt
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] dest_addr_q, dest_addr_d;
  logic              hdr_empty, dest_empty, dest_srst, hdr_valid;
  logic              wait_expired;

  // Port selection by compare rather than indexing keeps the reserved address
  // from ever reaching past the last destination.
  always_comb begin
    hdr_empty  = 1'b0;
    dest_empty = 1'b0;
    dest_srst  = 1'b0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      if (data_in == ADDR_W'(i)) begin
        hdr_empty = fifo_empty[i];
      end
      if (dest_addr_q == ADDR_W'(i)) begin
        dest_empty = fifo_empty[i];
        dest_srst  = soft_reset[i];
      end
    end
  end

  assign hdr_valid = pkt_valid && (data_in != ADDR_W'(ADDR_INVALID));

`ifdef ROUTER_FSM_TIMEOUT_EN
  logic drop_q, drop_d;

  router_fsm_watchdog #(
    .WAIT_TIMEOUT(WAIT_TIMEOUT)
  ) u_watchdog (
    .clk_i    (clock),
    .rst_i    (reset),
    .clear_i  ((state_q != WAIT_TILL_EMPTY) || dest_srst),
    .enable_i (state_q == WAIT_TILL_EMPTY),
    .timeout_o(wait_expired)
  );

  // An empty FIFO or a soft reset on the timeout cycle takes precedence over the drop.
  assign drop_d = wait_expired && !dest_empty && !dest_srst;

  always_ff @(posedge clock) begin
    if (reset) begin
      drop_q <= 1'b0;
    end else begin
      drop_q <= drop_d;
    end
  end

  assign drop_pkt = drop_q;
`else
  assign wait_expired = 1'b0;
  assign drop_pkt     = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    dest_addr_d = dest_addr_q;
    if ((state_q != DECODE_ADDRESS) && dest_srst) begin
      state_d = DECODE_ADDRESS;
    end else begin
      case (state_q)
        DECODE_ADDRESS: begin
          if (hdr_valid) begin
            dest_addr_d = data_in;
            state_d     = hdr_empty ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
          end
        end
        LOAD_FIRST_DATA: state_d = LOAD_DATA;
        LOAD_DATA: begin
          if (fifo_full) begin
            state_d = FIFO_FULL_STATE;
          end else if (!pkt_valid) begin
            state_d = LOAD_PARITY;
          end
        end
        LOAD_PARITY: state_d = CHECK_PARITY_ERROR;
        CHECK_PARITY_ERROR: state_d = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
        FIFO_FULL_STATE: begin
          if (!fifo_full) begin
            state_d = LOAD_AFTER_FULL;
          end
        end
        LOAD_AFTER_FULL: begin
          if (parity_done) begin
            state_d = DECODE_ADDRESS;
          end else if (low_packet_valid) begin
            state_d = LOAD_PARITY;
          end else begin
            state_d = LOAD_DATA;
          end
        end
        WAIT_TILL_EMPTY: begin
          if (dest_empty) begin
            state_d = LOAD_FIRST_DATA;
          end else if (wait_expired) begin
            state_d = DECODE_ADDRESS;
          end
        end
        default: state_d = DECODE_ADDRESS;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= DECODE_ADDRESS;
      dest_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      dest_addr_q <= dest_addr_d;
    end
  end

  always_comb begin
    detect_add    = 1'b0;
    lfd_state     = 1'b0;
    ld_state      = 1'b0;
    laf_state     = 1'b0;
    full_state    = 1'b0;
    rst_int_reg   = 1'b0;
    write_enb_reg = 1'b0;
    busy          = 1'b1;
    case (state_q)
      DECODE_ADDRESS: begin
        detect_add = 1'b1;
        busy       = 1'b0;
      end
      LOAD_FIRST_DATA: lfd_state = 1'b1;
      LOAD_DATA: begin
        ld_state      = 1'b1;
        write_enb_reg = 1'b1;
        busy          = 1'b0;
      end
      LOAD_PARITY: write_enb_reg = 1'b1;
      CHECK_PARITY_ERROR: rst_int_reg = 1'b1;
      FIFO_FULL_STATE: full_state = 1'b1;
      LOAD_AFTER_FULL: begin
        laf_state     = 1'b1;
        write_enb_reg = 1'b1;
      end
      default: ;
    endcase
  end

  assign dest_addr = dest_addr_q;

endmodule

// File: tb/tb_router_fsm.sv
// Table-driven, scoreboarded bench for router_fsm; the timeout section follows
// ROUTER_FSM_TIMEOUT_EN.
module tb_router_fsm;

  typedef enum int {S_DA, S_LFD, S_LD, S_LP, S_CPE, S_FFS, S_LAF, S_WTE} st_e;

  typedef struct {
    string      tag;
    logic       rst;
    logic       pv;
    logic [1:0] din;
    logic       full;
    logic [2:0] empty;
    logic [2:0] srst;
    logic       pdone;
    logic       lpv;
    st_e        st;
    logic [1:0] dest;
    logic       drop;
  } vec_t;

  logic       clock, reset, pkt_valid, fifo_full, parity_done, low_packet_valid;
  logic [1:0] data_in;
  logic [2:0] fifo_empty, soft_reset;
  logic       detect_add, lfd_state, ld_state, laf_state, full_state;
  logic       rst_int_reg, write_enb_reg, busy, drop_pkt;
  logic [1:0] dest_addr;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  logic [10:0] exp_q[$];
  vec_t        vecs[$];

  router_fsm #(
    .NUM_PORTS   (3),
    .ADDR_W      (2),
    .WAIT_TIMEOUT(30)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .pkt_valid       (pkt_valid),
    .data_in         (data_in),
    .fifo_full       (fifo_full),
    .fifo_empty      (fifo_empty),
    .soft_reset      (soft_reset),
    .parity_done     (parity_done),
    .low_packet_valid(low_packet_valid),
    .detect_add      (detect_add),
    .lfd_state       (lfd_state),
    .ld_state        (ld_state),
    .laf_state       (laf_state),
    .full_state      (full_state),
    .rst_int_reg     (rst_int_reg),
    .write_enb_reg   (write_enb_reg),
    .busy            (busy),
    .dest_addr       (dest_addr),
    .drop_pkt        (drop_pkt)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // {detect_add, lfd, ld, laf, full, rst_int, write_enb, busy}
  function automatic logic [7:0] strobes(input st_e s);
    case (s)
      S_DA:    return 8'b1000_0000;
      S_LFD:   return 8'b0100_0001;
      S_LD:    return 8'b0010_0010;
      S_LAF:   return 8'b0001_0011;
      S_FFS:   return 8'b0000_1001;
      S_CPE:   return 8'b0000_0101;
      S_LP:    return 8'b0000_0011;
      default: return 8'b0000_0001;
    endcase
  endfunction

  function automatic vec_t mk(input string tag, input logic rst, pv, input logic [1:0] din,
                              input logic full, input logic [2:0] empty, srst,
                              input logic pdone, lpv, input st_e st, input logic [1:0] dest,
                              input logic drop);
    vec_t v;
    v.tag = tag; v.rst = rst; v.pv = pv; v.din = din; v.full = full;
    v.empty = empty; v.srst = srst; v.pdone = pdone; v.lpv = lpv;
    v.st = st; v.dest = dest; v.drop = drop;
    return v;
  endfunction

  task automatic add(input string tag, input logic rst, pv, input logic [1:0] din,
                     input logic full, input logic [2:0] empty, srst,
                     input logic pdone, lpv, input st_e st, input logic [1:0] dest);
    vecs.push_back(mk(tag, rst, pv, din, full, empty, srst, pdone, lpv, st, dest, 1'b0));
  endtask

  task automatic step(input vec_t v);
    logic [10:0] got, e;
    reset = v.rst; pkt_valid = v.pv; data_in = v.din; fifo_full = v.full;
    fifo_empty = v.empty; soft_reset = v.srst; parity_done = v.pdone;
    low_packet_valid = v.lpv;
    exp_q.push_back({strobes(v.st), v.dest, v.drop});
    @(posedge clock);
    #1;
    got = {detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg,
           write_enb_reg, busy, dest_addr, drop_pkt};
    e = exp_q.pop_front();
    n_checks++;
    if (got === e) n_pass++;
    else $display("FAIL %s got=%b required=%b (strobes|dest|drop)", v.tag, got, e);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout bench did not finish");
    $display("%0d/%0d checks passed", n_pass, n_checks + 1);
    $fatal(1);
  end

  initial begin
    reset = 1'b1; pkt_valid = 1'b0; data_in = '0; fifo_full = 1'b0;
    fifo_empty = 3'b111; soft_reset = '0; parity_done = 1'b0; low_packet_valid = 1'b0;

    add("rst0",    1, 0, 0, 0, 3'b111, 3'b000, 0, 0, S_DA,  0);
    add("rst1",    1, 0, 0, 0, 3'b111, 3'b000, 0, 0, S_DA,  0);
    add("n_hdr",   0, 1, 1, 0, 3'b111, 3'b000, 0, 0, S_LFD, 1);
    add("n_lfd",   0, 1, 2, 0, 3'b111, 3'b000, 0, 0, S_LD,  1);
    add("n_ld1",   0, 1, 3, 0, 3'b111, 3'b000, 0, 0, S_LD,  1);
    add("n_ld2",   0, 1, 0, 0, 3'b111, 3'b000, 0, 0, S_LD,  1);
    add("n_ld3",   0, 0, 0, 0, 3'b111, 3'b000, 0, 0, S_LP,  1);
    add("n_lp",    0, 0, 0, 0, 3'b111, 3'b000, 0, 0, S_CPE, 1);
    add("n_cpe",   0, 0, 0, 0, 3'b111, 3'b000, 0, 0, S_DA,  1);
    add("f_hdr",   0, 1, 0, 0, 3'b111, 3'b000, 0, 0, S_LFD, 0);
    add("f_lfd",   0, 1, 0, 0, 3'b111, 3'b000, 0, 0, S_LD,  0);
    add("f_ld1",   0, 1, 0, 0, 3'b111, 3'b000, 0, 0, S_LD,  0);
    add("f_ld2",   0, 1, 0, 1, 3'b111, 3'b000, 0, 0, S_FFS, 0);
    add("f_ff1",   0, 1, 0, 1, 3'b111, 3'b000, 0, 0, S_FFS, 0);
    add("f_ff2",   0, 1, 0, 1, 3'b111, 3'b000, 0, 0, S_FFS, 0);
    add("f_ff3",   0, 1, 0, 1, 3'b111, 3'b000, 0, 0, S_FFS, 0);
    add("f_ff4",   0, 1, 0, 0, 3'b111, 3'b000, 0, 0, S_LAF, 0);
    add("f_laf",   0, 1, 0, 0, 3'b111, 3'b000, 0, 0, S_LD,  0);
    add("f_ld3",   0, 0, 0, 0, 3'b111, 3'b000, 0, 0, S_LP,  0);
    add("f_lp",    0, 0, 0, 0, 3'b111, 3'b000, 0, 0, S_CPE, 0);
    add("f_cpe",   0, 0, 0, 0, 3'b111, 3'b000, 0, 0, S_DA,  0);
    add("w_hdr",   0, 1, 2, 0, 3'b011, 3'b000, 0, 0, S_WTE, 2);
    for (int i = 0; i < 5; i++)
      add("w_wait", 0, 0, 0, 0, 3'b011, 3'b000, 0, 0, S_WTE, 2);
    add("w_go",    0, 0, 0, 0, 3'b100, 3'b000, 0, 0, S_LFD, 2);
    add("w_lfd",   0, 1, 0, 0, 3'b111, 3'b000, 0, 0, S_LD,  2);
    add("w_both",  0, 0, 0, 1, 3'b111, 3'b000, 0, 0, S_FFS, 2);
    add("w_ff",    0, 0, 0, 0, 3'b111, 3'b000, 0, 0, S_LAF, 2);
    add("w_lafl",  0, 0, 0, 0, 3'b111, 3'b000, 0, 1, S_LP,  2);
    add("w_lp",    0, 0, 0, 0, 3'b111, 3'b000, 0, 0, S_CPE, 2);
    add("w_cpef",  0, 0, 0, 1, 3'b111, 3'b000, 0, 0, S_FFS, 2);
    add("w_ff2",   0, 0, 0, 0, 3'b111, 3'b000, 0, 0, S_LAF, 2);
    add("w_lafp",  0, 0, 0, 0, 3'b111, 3'b000, 1, 1, S_DA,  2);
    add("inv",     0, 1, 3, 0, 3'b111, 3'b000, 0, 0, S_DA,  2);
    add("idle",    0, 0, 1, 0, 3'b111, 3'b000, 0, 0, S_DA,  2);
    add("s_hdr",   0, 1, 0, 0, 3'b111, 3'b000, 0, 0, S_LFD, 0);
    add("s_lfd",   0, 1, 0, 0, 3'b111, 3'b000, 0, 0, S_LD,  0);
    add("s_hit",   0, 1, 0, 0, 3'b111, 3'b001, 0, 0, S_DA,  0);
    add("s_hdr2",  0, 1, 0, 0, 3'b111, 3'b000, 0, 0, S_LFD, 0);
    add("s_lfd2",  0, 1, 0, 0, 3'b111, 3'b000, 0, 0, S_LD,  0);
    add("s_miss",  0, 1, 0, 0, 3'b111, 3'b100, 0, 0, S_LD,  0);
    add("s_end",   0, 0, 0, 0, 3'b111, 3'b000, 0, 0, S_LP,  0);
    add("s_lp",    0, 0, 0, 0, 3'b111, 3'b000, 0, 0, S_CPE, 0);
    add("s_cpe",   0, 0, 0, 0, 3'b111, 3'b000, 0, 0, S_DA,  0);
    add("s_dec",   0, 1, 1, 0, 3'b111, 3'b011, 0, 0, S_LFD, 1);
    add("s_lfdhit",0, 1, 1, 0, 3'b111, 3'b010, 0, 0, S_DA,  1);
    add("s_whdr",  0, 1, 1, 0, 3'b101, 3'b000, 0, 0, S_WTE, 1);
    add("s_whit",  0, 0, 0, 0, 3'b101, 3'b010, 0, 0, S_DA,  1);
    add("r_hdr",   0, 1, 2, 0, 3'b111, 3'b000, 0, 0, S_LFD, 2);
    add("r_lfd",   0, 1, 2, 0, 3'b111, 3'b000, 0, 0, S_LD,  2);
    add("r_mid",   1, 1, 2, 0, 3'b111, 3'b000, 0, 0, S_DA,  0);

    for (int i = 0; i < vecs.size(); i++) step(vecs[i]);

`ifdef ROUTER_FSM_TIMEOUT_EN
    // 30 WAIT cycles (row after header plus 29 holds), then abort with one-cycle drop.
    step(mk("t_hdr", 0, 1, 0, 0, 3'b110, 3'b000, 0, 0, S_WTE, 0, 0));
    for (int i = 1; i < 30; i++)
      step(mk("t_wait", 0, 0, 0, 0, 3'b110, 3'b000, 0, 0, S_WTE, 0, 0));
    step(mk("t_abort", 0, 0, 0, 0, 3'b110, 3'b000, 0, 0, S_DA, 0, 1));
    step(mk("t_after", 0, 0, 0, 0, 3'b110, 3'b000, 0, 0, S_DA, 0, 0));
    step(mk("e_hdr", 0, 1, 0, 0, 3'b110, 3'b000, 0, 0, S_WTE, 0, 0));
    for (int i = 1; i < 30; i++)
      step(mk("e_wait", 0, 0, 0, 0, 3'b110, 3'b000, 0, 0, S_WTE, 0, 0));
    step(mk("e_race", 0, 0, 0, 0, 3'b111, 3'b000, 0, 0, S_LFD, 0, 0));
    step(mk("e_lfd", 0, 1, 0, 0, 3'b111, 3'b000, 0, 0, S_LD, 0, 0));
`else
    step(mk("t_hdr", 0, 1, 0, 0, 3'b110, 3'b000, 0, 0, S_WTE, 0, 0));
    for (int i = 0; i < 40; i++)
      step(mk("t_nowdog", 0, 0, 0, 0, 3'b110, 3'b000, 0, 0, S_WTE, 0, 0));
    step(mk("t_go", 0, 0, 0, 0, 3'b001, 3'b000, 0, 0, S_LFD, 0, 0));
    step(mk("t_lfd", 0, 1, 0, 0, 3'b111, 3'b000, 0, 0, S_LD, 0, 0));
`endif
    step(mk("t_rst", 1, 0, 0, 0, 3'b111, 3'b000, 0, 0, S_DA, 0, 0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/router_fsm.md
Name: router_fsm

Overview:
- Packet-sequencing controller for the 1x3 router datapath.
- Decodes the header address and tracks destination FIFO status.
- Drives the phase strobes that make the register/parity block latch the header, payload and parity, and that let it recover from FIFO-full stalls.
- Drives busy back to the source and write enable to the synchronizer/FIFOs.

Parameters:
- NUM_PORTS, 3, number of destination FIFOs.
- ADDR_W, 2, header address field width, taken from data_in[1:0].
- WAIT_TIMEOUT, 30, cycles allowed in WAIT_TILL_EMPTY (only used with ROUTER_FSM_TIMEOUT_EN).

Ports:
- clock  input  1  system clock; all logic on posedge.
- reset  input  1  synchronous, active-high reset.
- pkt_valid  input  1  source asserts for header and payload bytes; deasserts with the parity byte.
- data_in  input  ADDR_W  header address bits.
- fifo_full  input  1  full flag of the currently selected destination FIFO.
- fifo_empty  input  NUM_PORTS  per-destination FIFO empty flags.
- soft_reset  input  NUM_PORTS  per-destination soft-reset pulses.
- parity_done  input  1  from register block.
- low_packet_valid  input  1  from register block.
- detect_add  output  1  high in DECODE_ADDRESS.
- lfd_state  output  1  high in LOAD_FIRST_DATA.
- ld_state  output  1  high in LOAD_DATA.
- laf_state  output  1  high in LOAD_AFTER_FULL.
- full_state  output  1  high in FIFO_FULL_STATE.
- rst_int_reg  output  1  high in CHECK_PARITY_ERROR.
- write_enb_reg  output  1  FIFO write enable.
- busy  output  1  source back-pressure.
- dest_addr  output  ADDR_W  latched destination of the current packet.
- drop_pkt  output  1  one-cycle pulse on a timeout abort (tied 0 without the feature).

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
  - Reset: state=DECODE_ADDRESS, dest_addr=0, drop_pkt=0.
  - Resulting output values: detect_add=1, busy=0, all other strobes 0.
- Outputs are Moore decodes of the state register; no input-to-output combinational paths.
  - write_enb_reg=1 in LOAD_DATA, LOAD_PARITY and LOAD_AFTER_FULL.
  - busy=1 in every state except DECODE_ADDRESS and LOAD_DATA.
- Address latch: dest_addr<=data_in when state is DECODE_ADDRESS and pkt_valid=1 and data_in!=3.
- Transitions, priority order: reset > soft_reset[dest_addr] (any state except DECODE_ADDRESS -> DECODE_ADDRESS) > the table below.
  - DECODE_ADDRESS:
    - pkt_valid and addr<3 and fifo_empty[addr] -> LOAD_FIRST_DATA.
    - pkt_valid and addr<3 and not empty -> WAIT_TILL_EMPTY.
    - addr==3 -> stay; the packet is ignored, dest_addr unchanged.
  - LOAD_FIRST_DATA -> LOAD_DATA, unconditional (1 cycle).
  - LOAD_DATA: fifo_full -> FIFO_FULL_STATE; else !pkt_valid -> LOAD_PARITY; else stay.
  - LOAD_PARITY -> CHECK_PARITY_ERROR, unconditional.
  - CHECK_PARITY_ERROR: fifo_full -> FIFO_FULL_STATE; else -> DECODE_ADDRESS.
  - FIFO_FULL_STATE: stay while fifo_full; else -> LOAD_AFTER_FULL.
  - LOAD_AFTER_FULL:
    - parity_done -> DECODE_ADDRESS.
    - else low_packet_valid -> LOAD_PARITY.
    - else -> LOAD_DATA.
  - WAIT_TILL_EMPTY: fifo_empty[dest_addr] -> LOAD_FIRST_DATA; else stay.
- Boundary conditions:
  - fifo_full and !pkt_valid in the same LOAD_DATA cycle: full wins. Parity is recovered via LOAD_AFTER_FULL, since low_packet_valid is set by the register block.
  - soft_reset on a non-selected port is ignored.
  - A soft_reset pulse coinciding with a transition out of DECODE_ADDRESS is ignored.
  - Minimum packet latency, header to DECODE_ADDRESS: 5 cycles with no stalls (DECODE, LFD, LD, LP, CPE).
  - A state register holding an illegal encoding recovers to DECODE_ADDRESS on the next cycle.

Optional Feature:
- ROUTER_FSM_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to WAIT_TILL_EMPTY and increments each cycle spent there.
  - When the count reaches WAIT_TIMEOUT-1 while the FIFO is still non-empty, the next state is DECODE_ADDRESS and drop_pkt pulses 1 cycle.
  - An empty FIFO on the same cycle as the timeout wins: the packet proceeds to LOAD_FIRST_DATA and no drop occurs.
  - reset and soft_reset clear the counter.
- Undefined: no counter; WAIT_TILL_EMPTY waits indefinitely; drop_pkt is constant 0.

Decomposition:
- Shared package router_pkg holds:
  - state encoding localparams (8 states, 3-bit);
  - ADDR_INVALID=2'd3;
  - the NUM_PORTS and ADDR_W defaults.
- Natural sub-module: router_fsm_watchdog, the WAIT_TIMEOUT counter with inputs clear/enable and a timeout output, instantiated only under ROUTER_FSM_TIMEOUT_EN.

Test Plan:
- Normal packet: reset 2 cycles, then header addr=1 with fifo_empty=3'b111, then 3 payload bytes, then parity.
  - Required state sequence: DECODE -> LFD -> LD x3 -> LP -> CPE -> DECODE.
  - busy=1 in LFD, LP and CPE; dest_addr=1.
- Full stall: fifo_full=1 on the 2nd LD cycle, held 4 cycles.
  - Required: full_state=1 for 4 cycles, then laf_state for 1 cycle, then back to LD.
  - write_enb_reg=0 during the stall.
- Busy destination: header addr=2 with fifo_empty[2]=0 for 6 cycles, then 1.
  - Required: WAIT_TILL_EMPTY for 6 cycles, then LFD; busy=1 throughout.
- Invalid address: header data_in=3 with pkt_valid=1.
  - Required: remain in DECODE, detect_add=1, dest_addr unchanged.
- Soft reset:
  - soft_reset[0] pulsed during LD of an addr-0 packet -> DECODE next cycle.
  - soft_reset[2] in the same situation -> no effect.
- Timeout (feature on, WAIT_TIMEOUT=30): addr=0 with fifo_empty[0]=0 held.
  - Required: DECODE after exactly 30 WAIT cycles, with drop_pkt high for 1 cycle.
